fft_power_spectrum: RTL and testbench
=====================================

// Module: fft_power_spectrum
// PURPOSE
//  Consumes the streaming complex output of the STFFT stage (one bin per i_ce, i_fft_sync on bin 0).
//  Computes per-bin power re^2+im^2 for the non-redundant half-spectrum, bins 0..FFT_SIZE/2.
//  Buffers the results in a FIFO and presents them on a valid/ready stream to the feature-extraction
//  stage (mel filterbank). Decouples the FFT's ce-paced output from a back-pressuring consumer.
// PARAMETERS
//  IW         18   signed width of each real/imag component at input
//  PW         36   output power width; o_power = sum[2*IW-1 -: PW] (LSB truncation, PW<=2*IW)
//  FFT_SIZE   256  FFT length, power of two; LGNFFT=$clog2(FFT_SIZE)
//  FIFO_DEPTH 256  output FIFO entries, power of two, >= FFT_SIZE/2+1
// PORTS
//  i_clk           in   1         clock
//  i_reset         in   1         asynchronous active-high reset
//  i_ce            in   1         input bin valid this cycle
//  i_fft_result    in   2*IW      {re[IW-1:0], im[IW-1:0]}, two's complement
//  i_fft_sync      in   1         qualified by i_ce; marks bin 0 of a frame
//  o_power         out  PW        bin power
//  o_bin           out  LGNFFT    bin index of o_power
//  o_last          out  1         o_bin == FFT_SIZE/2
//  o_valid         out  1         output entry available
//  i_ready         in   1         consumer accepts when o_valid & i_ready
//  o_overflow      out  1         sticky: a bin was dropped because the FIFO was full
// BEHAVIOUR
//  Reset (async): all outputs 0, FIFO empty, locked=0, bin counter 0, pipeline valids 0.
//  Lock: bins are discarded until the first i_ce&i_fft_sync; then locked=1 until reset.
//  Bin counter: i_ce&i_fft_sync -> bin=0 (also mid-frame: early resync restarts at 0);
//   i_ce alone -> bin+1, wraps FFT_SIZE-1 -> 0. Bins > FFT_SIZE/2 are discarded.
//  Pipeline (free-running, valid-tagged, never stalls):
//   S1 register re, im, bin; S2 squares re*re, im*im (2*IW bits each, unsigned result);
//   S3 sum (fits 2*IW bits, max 2^(2*IW-1)) -> truncate to PW -> FIFO write.
//  Latency: i_ce at cycle N -> FIFO write at N+3 -> o_valid high at N+4 (empty FIFO, FWFT).
//  FIFO: show-ahead; o_power/o_bin/o_last are stable while o_valid & ~i_ready.
//   Pop on o_valid&i_ready. Write and pop in the same cycle are allowed, including when full.
//   Write when full and no pop: entry dropped, o_overflow<=1 (sticky until reset).
//   Later entries keep correct o_bin, because the bin is stored per entry.
//  Empty: o_valid=0, outputs hold their last values. i_ready while empty has no effect.
//  i_ce gaps: the pipeline drains normally; no bubble corrupts data.
// CONFIGURATION
//  FFT_POWER_FRAME_ENERGY_EN defined: adds outputs o_energy [PW+LGNFFT-1:0] and o_energy_valid.
//   An accumulator sums every written power of the current frame. It clears on the bin-0 write.
//   A 1-cycle o_energy_valid pulse fires on the cycle after the bin FFT_SIZE/2 write.
//   o_energy holds until the next pulse. Dropped (overflowed) bins are still accumulated.
//   Reset clears both outputs to 0.
//  Not defined: ports absent, no accumulator logic.
// TESTING
//  1 Reset, then 300 i_ce with no sync -> o_valid never rises, o_overflow=0.
//  2 Sync, bin0 re=3 im=-4, other bins 0, i_ready=1 -> o_power=25, o_bin=0 at 4 cycles after i_ce.
//    Exactly 129 outputs follow, the last with o_bin=128 and o_last=1.
//  3 re=im=-131072 (IW=18) -> o_power=34359738368 (2^35), no sign or width error.
//    With PW=32: o_power=2^31.
//  4 i_ready=0, FIFO_DEPTH=256, two frames (258 kept bins) -> 256 stored, o_overflow=1.
//    Drain shows bins 0..128 then 0..126 in order.
//  5 Sync reasserted at bin 50 -> next output o_bin=0; no output carries o_bin 51..128 for the aborted frame.
//  6 FFT_POWER_FRAME_ENERGY_EN, all bins re=1 im=1 -> one o_energy_valid pulse per frame, o_energy=258.
//    Assert i_reset mid-frame -> o_energy=0, o_valid=0 immediately.

Source files
------------

// File: rtl/fft_power_spectrum.sv
// Per-bin power (re^2+im^2) of the half-spectrum of a streaming FFT, buffered in a show-ahead FIFO.
// Define FFT_POWER_FRAME_ENERGY_EN to add the per-frame energy outputs o_energy/o_energy_valid.
module fft_power_spectrum #(
    parameter int IW         = 18,
    parameter int PW         = 36,
    parameter int FFT_SIZE   = 256,
    parameter int FIFO_DEPTH = 256,
    localparam int LGNFFT    = $clog2(FFT_SIZE)
) (
    input  logic                 i_clk,
    input  logic                 i_reset,
    input  logic                 i_ce,
    input  logic [2*IW-1:0]      i_fft_result,
    input  logic                 i_fft_sync,
    output logic [PW-1:0]        o_power,
    output logic [LGNFFT-1:0]    o_bin,
    output logic                 o_last,
    output logic                 o_valid,
    input  logic                 i_ready,
    output logic                 o_overflow
`ifdef FFT_POWER_FRAME_ENERGY_EN
    ,
    output logic [PW+LGNFFT-1:0] o_energy,
    output logic                 o_energy_valid
`endif
);

    localparam int SW = 2 * IW;
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int EW = PW + LGNFFT + 1;
    localparam logic [LGNFFT-1:0] LAST_BIN = LGNFFT'(FFT_SIZE / 2);

    function automatic logic [PW-1:0] trunc_power(input logic [SW-1:0] sum);
        return sum[SW-1 -: PW];
    endfunction

    logic                     locked;
    logic [LGNFFT-1:0]        bin_cnt;
    logic [LGNFFT-1:0]        cur_bin;
    logic                     keep;

    logic                     vld_p0, vld_p1, vld_p2;
    logic signed [IW-1:0]     re_p0, im_p0;
    logic [LGNFFT-1:0]        bin_p0, bin_p1, bin_p2;
    logic signed [SW-1:0]     sq_re_p1, sq_im_p1;
    logic [SW-1:0]            sum_p2;

    // Early resync restarts the frame at bin 0; the upper redundant half is never kept.
    always_comb begin
        cur_bin = i_fft_sync ? '0 : bin_cnt + 1'b1;
        keep    = i_ce && (locked || i_fft_sync) && (cur_bin <= LAST_BIN);
    end

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            locked  <= 1'b0;
            bin_cnt <= '0;
            vld_p0  <= 1'b0;
            vld_p1  <= 1'b0;
            vld_p2  <= 1'b0;
        end else begin
            if (i_ce) begin
                bin_cnt <= cur_bin;
                if (i_fft_sync)
                    locked <= 1'b1;
            end
            vld_p0 <= keep;
            vld_p1 <= vld_p0;
            vld_p2 <= vld_p1;
        end
    end

    always_ff @(posedge i_clk) begin
        // p0: capture components and bin index
        re_p0    <= i_fft_result[SW-1 -: IW];
        im_p0    <= i_fft_result[IW-1:0];
        bin_p0   <= cur_bin;
        // p1: squares, each non-negative and at most 2^(SW-2)
        sq_re_p1 <= SW'(re_p0) * SW'(re_p0);
        sq_im_p1 <= SW'(im_p0) * SW'(im_p0);
        bin_p1   <= bin_p0;
        // p2: unsigned sum, at most 2^(SW-1) so it fits SW bits
        sum_p2   <= $unsigned(sq_re_p1) + $unsigned(sq_im_p1);
        bin_p2   <= bin_p1;
    end

    // The output register is the FIFO head; the array holds the remaining entries.
    logic [EW-1:0]  mem [FIFO_DEPTH];
    logic [AW-1:0]  wr_ptr, rd_ptr;
    logic [AW:0]    mem_cnt;
    logic [EW-1:0]  wr_data, rd_data;
    logic           pop, full, accept, load_out, from_mem, to_mem;

    always_comb begin
        wr_data  = {trunc_power(sum_p2), bin_p2, bin_p2 == LAST_BIN};
        rd_data  = mem[rd_ptr];
        pop      = o_valid & i_ready;
        full     = (mem_cnt + (AW+1)'(o_valid)) == (AW+1)'(FIFO_DEPTH);
        accept   = vld_p2 & (~full | pop);
        load_out = ~o_valid | pop;
        from_mem = load_out & (mem_cnt != '0);
        to_mem   = accept & ~(load_out & (mem_cnt == '0));
    end

    always_ff @(posedge i_clk) begin
        if (to_mem)
            mem[wr_ptr] <= wr_data;
    end

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            mem_cnt    <= '0;
            o_valid    <= 1'b0;
            o_power    <= '0;
            o_bin      <= '0;
            o_last     <= 1'b0;
            o_overflow <= 1'b0;
        end else begin
            if (to_mem)
                wr_ptr <= wr_ptr + 1'b1;
            if (from_mem)
                rd_ptr <= rd_ptr + 1'b1;
            mem_cnt <= mem_cnt + (AW+1)'(to_mem) - (AW+1)'(from_mem);
            if (load_out) begin
                if (from_mem) begin
                    {o_power, o_bin, o_last} <= rd_data;
                    o_valid <= 1'b1;
                end else if (accept) begin
                    {o_power, o_bin, o_last} <= wr_data;
                    o_valid <= 1'b1;
                end else begin
                    o_valid <= 1'b0;
                end
            end
            if (vld_p2 && full && !pop)
                o_overflow <= 1'b1;
        end
    end

`ifdef FFT_POWER_FRAME_ENERGY_EN
    logic [PW+LGNFFT-1:0] energy_acc;
    logic [PW+LGNFFT-1:0] energy_next;

    // Every computed bin counts, including those the full FIFO drops.
    always_comb begin
        energy_next = (PW+LGNFFT)'(trunc_power(sum_p2));
        if (bin_p2 != '0)
            energy_next = energy_next + energy_acc;
    end

    always_ff @(posedge i_clk) begin
        if (vld_p2)
            energy_acc <= energy_next;
    end

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            o_energy       <= '0;
            o_energy_valid <= 1'b0;
        end else begin
            o_energy_valid <= vld_p2 && (bin_p2 == LAST_BIN);
            if (vld_p2 && (bin_p2 == LAST_BIN))
                o_energy <= energy_next;
        end
    end
`endif

endmodule

// File: tb/tb_fft_power_spectrum.sv
// Scoreboard bench for fft_power_spectrum: expected bin powers are queued as bins are driven.
module tb_fft_power_spectrum;

    localparam int IW         = 18;
    localparam int PW         = 36;
    localparam int FFT_SIZE   = 256;
    localparam int FIFO_DEPTH = 256;
    localparam int LG         = 8;
    localparam int HALF       = FFT_SIZE / 2;

    logic              clk = 1'b0;
    logic              rst;
    logic              ce;
    logic              sync;
    logic              ready;
    logic [2*IW-1:0]   din;
    logic [PW-1:0]     power;
    logic [LG-1:0]     bin;
    logic              last;
    logic              valid;
    logic              ovf;
`ifdef FFT_POWER_FRAME_ENERGY_EN
    logic [PW+LG-1:0]  energy;
    logic              energy_valid;
`endif

    always #5 clk = ~clk;

    fft_power_spectrum #(
        .IW(IW), .PW(PW), .FFT_SIZE(FFT_SIZE), .FIFO_DEPTH(FIFO_DEPTH)
    ) dut (
        .i_clk(clk),
        .i_reset(rst),
        .i_ce(ce),
        .i_fft_result(din),
        .i_fft_sync(sync),
        .o_power(power),
        .o_bin(bin),
        .o_last(last),
        .o_valid(valid),
        .i_ready(ready),
        .o_overflow(ovf)
`ifdef FFT_POWER_FRAME_ENERGY_EN
        ,
        .o_energy(energy),
        .o_energy_valid(energy_valid)
`endif
    );

    typedef struct {
        logic [PW-1:0] power;
        logic [LG-1:0] bin;
        logic          last;
    } exp_t;

    exp_t sb[$];
    int   checks   = 0;
    int   failures = 0;
    bit   m_locked;
    int   m_bin;
    bit   m_ovf;

    function automatic int rnd();
        return int'($urandom_range(0, (1 << IW) - 1)) - (1 << (IW - 1));
    endfunction

    // One clock of stimulus; the reference model queues the expected entry for kept bins.
    task automatic cycle(input bit c, input bit s, input int re, input int im, input bit r);
        exp_t   e;
        longint p;
        @(posedge clk);
        #1;
        ce    = c;
        sync  = s;
        ready = r;
        din   = {re[IW-1:0], im[IW-1:0]};
        if (c) begin
            if (s) begin
                m_locked = 1'b1;
                m_bin    = 0;
            end else begin
                m_bin = (m_bin + 1) % FFT_SIZE;
            end
            if (m_locked && m_bin <= HALF) begin
                p       = longint'(re) * re + longint'(im) * im;
                e.power = p[2*IW-1 -: PW];
                e.bin   = m_bin[LG-1:0];
                e.last  = (m_bin == HALF);
                if (sb.size() < FIFO_DEPTH) sb.push_back(e);
                else m_ovf = 1'b1;
            end
        end
        @(negedge clk);
    endtask

    task automatic do_reset();
        @(posedge clk);
        #1;
        rst = 1'b1; ce = 1'b0; sync = 1'b0; ready = 1'b0; din = '0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        sb.delete();
        m_locked = 1'b0; m_bin = 0; m_ovf = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_reset();
        rst = 1'b1; ce = 1'b0; sync = 1'b0; ready = 1'b0; din = '0;
        #1;
        checks++;
        if ({valid, ovf} !== 2'b00) begin
            failures++;
            $display("FAIL reset_flags: got valid=%0b overflow=%0b, required 0 0", valid, ovf);
        end
        checks++;
        if ({power, bin, last} !== '0) begin
            failures++;
            $display("FAIL reset_data: got power=%0d bin=%0d last=%0b, required 0", power, bin, last);
        end
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
    endtask

    task automatic test_no_sync();
        do_reset();
        for (int i = 0; i < 310; i++) begin
            if (i < 300) cycle(1'b1, 1'b0, rnd(), rnd(), 1'b1);
            else cycle(1'b0, 1'b0, 0, 0, 1'b1);
            checks++;
            if (valid !== 1'b0) begin
                failures++;
                $display("FAIL nosync_valid: got valid=%0b at cycle %0d, required 0", valid, i);
            end
        end
        checks++;
        if (ovf !== 1'b0) begin
            failures++;
            $display("FAIL nosync_overflow: got %0b, required 0", ovf);
        end
    endtask

    task automatic test_frame();
        exp_t e;
        int   outs = 0;
        do_reset();
        for (int i = 0; i < 400; i++) begin
            if (i < 256) cycle(1'b1, i == 0, (i == 0) ? 3 : 0, (i == 0) ? -4 : 0, 1'b1);
            else cycle(1'b0, 1'b0, 0, 0, 1'b1);
            if (i == 3) begin
                checks++;
                if (valid !== 1'b0) begin
                    failures++;
                    $display("FAIL frame_latency_early: got valid=%0b, required 0", valid);
                end
            end
            if (i == 4) begin
                checks++;
                if ({valid, power, bin} !== {1'b1, 36'd25, 8'd0}) begin
                    failures++;
                    $display("FAIL frame_first: got valid=%0b power=%0d bin=%0d, required 1 25 0", valid, power, bin);
                end
            end
            if (valid && ready) begin
                checks++;
                outs++;
                if (sb.size() == 0) begin
                    failures++;
                    $display("FAIL frame_extra: got bin=%0d power=%0d, required no output", bin, power);
                end else begin
                    e = sb.pop_front();
                    if ({power, bin, last} !== {e.power, e.bin, e.last}) begin
                        failures++;
                        $display("FAIL frame_data: got power=%0d bin=%0d last=%0b, required power=%0d bin=%0d last=%0b",
                                 power, bin, last, e.power, e.bin, e.last);
                    end
                end
            end
            if (i >= 264 && sb.size() == 0) break;
        end
        checks++;
        if (sb.size() != 0 || outs != 129) begin
            failures++;
            $display("FAIL frame_count: got %0d outputs (%0d pending), required 129", outs, sb.size());
        end
        checks++;
        if ({valid, bin, last} !== {1'b0, 8'd128, 1'b1}) begin
            failures++;
            $display("FAIL frame_hold: got valid=%0b bin=%0d last=%0b, required 0 128 1", valid, bin, last);
        end
    endtask

    task automatic test_extreme();
        exp_t e;
        int   re, im;
        do_reset();
        for (int i = 0; i < 400; i++) begin
            re = rnd(); im = rnd();
            if (i == 0) begin re = -131072; im = -131072; end
            if (i == 1) begin re = 131071;  im = -131072; end
            if (i == 2) begin re = 131071;  im = 131071;  end
            if (i < 256) cycle(1'b1, i == 0, re, im, 1'b1);
            else cycle(1'b0, 1'b0, 0, 0, 1'b1);
            if (valid && ready && bin == 8'd0) begin
                checks++;
                if (power !== 36'd34359738368) begin
                    failures++;
                    $display("FAIL extreme_bin0: got %0d, required 34359738368", power);
                end
            end
            if (valid && ready) begin
                checks++;
                if (sb.size() == 0) begin
                    failures++;
                    $display("FAIL extreme_extra: got bin=%0d power=%0d, required no output", bin, power);
                end else begin
                    e = sb.pop_front();
                    if ({power, bin, last} !== {e.power, e.bin, e.last}) begin
                        failures++;
                        $display("FAIL extreme_data: got power=%0d bin=%0d last=%0b, required power=%0d bin=%0d last=%0b",
                                 power, bin, last, e.power, e.bin, e.last);
                    end
                end
            end
            if (i >= 264 && sb.size() == 0) break;
        end
        checks++;
        if (sb.size() != 0) begin
            failures++;
            $display("FAIL extreme_drain: got %0d pending, required 0", sb.size());
        end
    endtask

    task automatic test_overflow();
        exp_t e;
        int   outs = 0;
        do_reset();
        for (int i = 0; i < 518; i++) begin
            if (i < 512) cycle(1'b1, (i % 256) == 0, rnd(), rnd(), 1'b0);
            else cycle(1'b0, 1'b0, 0, 0, 1'b0);
        end
        checks++;
        if ({ovf, valid, bin} !== {1'b1, 1'b1, 8'd0}) begin
            failures++;
            $display("FAIL overflow_flag: got overflow=%0b valid=%0b bin=%0d, required 1 1 0", ovf, valid, bin);
        end
        for (int i = 0; i < 300; i++) begin
            cycle(1'b0, 1'b0, 0, 0, 1'b1);
            if (valid && ready) begin
                checks++;
                outs++;
                if (sb.size() == 0) begin
                    failures++;
                    $display("FAIL overflow_extra: got bin=%0d power=%0d, required no output", bin, power);
                end else begin
                    e = sb.pop_front();
                    if ({power, bin, last} !== {e.power, e.bin, e.last}) begin
                        failures++;
                        $display("FAIL overflow_data: got power=%0d bin=%0d last=%0b, required power=%0d bin=%0d last=%0b",
                                 power, bin, last, e.power, e.bin, e.last);
                    end
                end
            end
            if (i > 260) break;
        end
        checks++;
        if (outs != 256 || sb.size() != 0 || valid !== 1'b0) begin
            failures++;
            $display("FAIL overflow_drain: got %0d entries valid=%0b, required 256 and empty", outs, valid);
        end
        checks++;
        if (ovf !== 1'b1) begin
            failures++;
            $display("FAIL overflow_sticky: got %0b, required 1", ovf);
        end
    endtask

    task automatic test_resync();
        exp_t e;
        int   outs = 0;
        do_reset();
        for (int i = 0; i < 450; i++) begin
            if (i < 306) cycle(1'b1, i == 0 || i == 50, rnd(), rnd(), 1'b1);
            else cycle(1'b0, 1'b0, 0, 0, 1'b1);
            if (valid && ready) begin
                checks++;
                outs++;
                if (sb.size() == 0) begin
                    failures++;
                    $display("FAIL resync_extra: got bin=%0d power=%0d, required no output", bin, power);
                end else begin
                    e = sb.pop_front();
                    if ({power, bin, last} !== {e.power, e.bin, e.last}) begin
                        failures++;
                        $display("FAIL resync_data: got power=%0d bin=%0d last=%0b, required power=%0d bin=%0d last=%0b",
                                 power, bin, last, e.power, e.bin, e.last);
                    end
                end
            end
            if (i >= 314 && sb.size() == 0) break;
        end
        checks++;
        if (outs != 179 || sb.size() != 0) begin
            failures++;
            $display("FAIL resync_count: got %0d outputs, required 179", outs);
        end
    endtask

    task automatic test_back_to_back();
        exp_t            e;
        int              nce  = 0;
        int              idle = 0;
        bit              hold = 1'b0;
        logic [PW+LG:0]  held = '0;
        do_reset();
        for (int i = 0; i < 4000; i++) begin
            bit c;
            c = (nce < 768) && ($urandom_range(0, 3) != 0);
            cycle(c, c && (nce % 256) == 0, rnd(), rnd(), 1'($urandom_range(0, 1)));
            if (c) nce++;
            if (hold) begin
                checks++;
                if ({power, bin, last} !== held) begin
                    failures++;
                    $display("FAIL b2b_hold: got power=%0d bin=%0d, required unchanged bin=%0d", power, bin, held[LG:1]);
                end
            end
            hold = valid && !ready;
            held = {power, bin, last};
            if (valid && ready) begin
                checks++;
                if (sb.size() == 0) begin
                    failures++;
                    $display("FAIL b2b_extra: got bin=%0d power=%0d, required no output", bin, power);
                end else begin
                    e = sb.pop_front();
                    if ({power, bin, last} !== {e.power, e.bin, e.last}) begin
                        failures++;
                        $display("FAIL b2b_data: got power=%0d bin=%0d last=%0b, required power=%0d bin=%0d last=%0b",
                                 power, bin, last, e.power, e.bin, e.last);
                    end
                end
            end
            if (nce >= 768) idle++;
            if (idle > 8 && sb.size() == 0) break;
        end
        checks++;
        if (sb.size() != 0 || ovf !== 1'b0) begin
            failures++;
            $display("FAIL b2b_end: got %0d pending overflow=%0b, required 0 0", sb.size(), ovf);
        end
    endtask

`ifdef FFT_POWER_FRAME_ENERGY_EN
    task automatic test_energy();
        int pulses = 0;
        do_reset();
        for (int i = 0; i < 560; i++) begin
            if (i < 512) cycle(1'b1, (i % 256) == 0, 1, 1, 1'b1);
            else cycle(1'b0, 1'b0, 0, 0, 1'b1);
            if (energy_valid) begin
                pulses++;
                checks++;
                if (energy !== 44'd258) begin
                    failures++;
                    $display("FAIL energy_value: got %0d, required 258", energy);
                end
            end
        end
        checks++;
        if (pulses != 2) begin
            failures++;
            $display("FAIL energy_pulses: got %0d, required 2", pulses);
        end
        for (int i = 0; i < 60; i++) cycle(1'b1, i == 0, 1, 1, 1'b1);
        #1 rst = 1'b1;
        #1;
        checks++;
        if ({energy, energy_valid, valid} !== '0) begin
            failures++;
            $display("FAIL energy_reset: got energy=%0d pulse=%0b valid=%0b, required 0", energy, energy_valid, valid);
        end
        @(posedge clk);
        #1 rst = 1'b0;
    endtask
`endif

    initial begin
        test_reset();
        test_no_sync();
        test_frame();
        test_extreme();
        test_overflow();
        test_resync();
        test_back_to_back();
`ifdef FFT_POWER_FRAME_ENERGY_EN
        test_energy();
`endif
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
